// File: rtl/instr_byte_serializer_pkg.sv
// Shared definitions for the instruction byte link: opcode encoding,
// instruction width and opcode classification helpers.
package instr_byte_serializer_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      R_TYPE  = 3'd0,
      I_TYPE  = 3'd1,
      B_TYPE  = 3'd2,
      J_TYPE  = 3'd3,
      M_TYPE  = 3'd4,
      SYS_END = 3'd5
   } opcode_t;

   // I and M instructions carry an immediate and go out as four bytes.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == I_TYPE) || (op == M_TYPE);
   endfunction

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == R_TYPE) || (op == I_TYPE) || (op == B_TYPE) ||
             (op == J_TYPE) || (op == M_TYPE) || (op == SYS_END);
   endfunction

endpackage

// File: rtl/instr_byte_serializer_if.sv
// Instruction push handshake plus the byte link towards the CPU's
// instruction shift register.
interface instr_byte_serializer_if;
   import instr_byte_serializer_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [INSTR_W-1:0] in_imm;
   logic               tx_en;
   logic [7:0]         serial_out;
   logic               data_ready;

   modport master (
      output in_valid, in_instr, in_imm, tx_en,
      input  in_ready, serial_out, data_ready
   );

   modport slave (
      input  in_valid, in_instr, in_imm, tx_en,
      output in_ready, serial_out, data_ready
   );

endinterface

// File: rtl/instr_byte_serializer_fifo.sv
// Synchronous DEPTH-entry FIFO; pointers carry an extra wrap bit so that
// full and empty are told apart without an occupancy counter.
module instr_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/instr_byte_serializer.sv
// Buffers whole instructions and emits them little-endian, one byte per
// tx_en cycle, with a mandatory idle gap after every instruction.
module instr_byte_serializer
   import instr_byte_serializer_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   instr_byte_serializer_if.slave   bus,
   output logic                     busy,
   output logic                     halted,
   output logic                     err,
   output logic [15:0]              sent_count
);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_B0, S_B1, S_B2, S_B3, S_GAP, S_HALTED
   } state_t;

   state_t                state_q, state_d;
   logic [2*INSTR_W-1:0]  hold_q, hold_d;
   logic [7:0]            last_byte_q, last_byte_d;
   logic [15:0]           sent_count_q, sent_count_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

   logic [2*INSTR_W-1:0]  fifo_rdata;
   logic                  fifo_full, fifo_empty, fifo_pop;
   logic                  strobe, done;
   logic [7:0]            cur_byte;
   logic [2:0]            op;

   instr_fifo #(.DEPTH(DEPTH), .WIDTH(2*INSTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.in_valid && bus.in_ready),
      .wdata ({bus.in_imm, bus.in_instr}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign op = hold_q[2:0];

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      last_byte_d  = last_byte_q;
      sent_count_d = sent_count_q;
      gap_cnt_d    = gap_cnt_q;
      fifo_pop     = 1'b0;
      err          = 1'b0;
      strobe       = 1'b0;
      done         = 1'b0;
      cur_byte     = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               hold_d   = fifo_rdata;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (is_legal_op(op)) begin
               state_d = S_B0;
            end else begin
               err     = !rst;
               state_d = S_IDLE;
            end
         end
         S_B0: begin
            cur_byte = hold_q[7:0];
            if (bus.tx_en) state_d = S_B1;
         end
         S_B1: begin
            cur_byte = hold_q[15:8];
            if (bus.tx_en) begin
               if (is_long_op(op)) state_d = S_B2;
               else                done    = 1'b1;
            end
         end
         S_B2: begin
            cur_byte = hold_q[23:16];
            if (bus.tx_en) state_d = S_B3;
         end
         S_B3: begin
            cur_byte = hold_q[31:24];
            if (bus.tx_en) done = 1'b1;
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = (op == SYS_END) ? S_HALTED : S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         S_HALTED: ;
         default: state_d = S_IDLE;
      endcase

      if (state_q inside {S_B0, S_B1, S_B2, S_B3}) strobe = bus.tx_en && !rst;
      if (strobe) last_byte_d = cur_byte;
      if (done) begin
         sent_count_d = sent_count_q + 16'd1;
         gap_cnt_d    = '0;
         state_d      = S_GAP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         last_byte_q  <= 8'h00;
         sent_count_q <= 16'h0000;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         last_byte_q  <= last_byte_d;
         sent_count_q <= sent_count_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   // serial_out only moves on a strobe, so the receiver sees a stable bus otherwise.
   assign bus.serial_out = strobe ? cur_byte : last_byte_q;
   assign bus.data_ready = strobe;
   assign bus.in_ready   = !fifo_full && (state_q != S_HALTED) && !rst;
   assign halted         = (state_q == S_HALTED);
   assign busy           = ((state_q != S_IDLE) && (state_q != S_HALTED)) || !fifo_empty;
   assign sent_count     = sent_count_q;

endmodule

// File: tb/tb_instr_byte_serializer.sv
// Randomized and directed stimulus for instr_byte_serializer, checked against
// a queue-based model of the instruction byte stream.
module tb_instr_byte_serializer;
   import instr_byte_serializer_pkg::*;

   localparam int DEPTH = 2;
   localparam int GAP   = 1;
   localparam int NEVER = 32'h7fff_ffff;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy, halted, err;
   logic [15:0] sent_count;

   instr_byte_serializer_if bus();

   instr_byte_serializer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .halted     (halted),
      .err        (err),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference rules: legal opcodes 0..5, I(1)/M(4) send four bytes, little-endian.
   function automatic bit legal(input logic [15:0] instr);
      return instr[2:0] <= 3'd5;
   endfunction

   function automatic int nbytes(input logic [15:0] instr);
      return (instr[2:0] == 3'd1 || instr[2:0] == 3'd4) ? 4 : 2;
   endfunction

   function automatic logic [7:0] exp_byte(input item_t it, input int i);
      case (i)
         0:       return it.instr[7:0];
         1:       return it.instr[15:8];
         2:       return it.imm[7:0];
         default: return it.imm[15:8];
      endcase
   endfunction

   item_t       exp_q[$];
   int          strobe_cyc[$];
   int          push_cyc[$];
   int          byte_idx = 0;
   int          model_sent = 0;
   int          err_seen = 0;
   int          illegal_pushed = 0;
   int          cyc = 0;
   int          halt_cyc = NEVER;
   int          last_end_cyc = -1;
   bit          gap_pend = 0;
   bit          err_prev = 0;
   bit          prev_valid = 0;
   bit          stall_seen = 0;
   logic [7:0]  prev_serial = 8'h00;
   int          tx_mode = 0;   // 0: held high, 1: random, 2: toggling

   initial begin
      bus.tx_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (tx_mode)
            1:       bus.tx_en = 1'($urandom_range(0, 1));
            2:       bus.tx_en = ~bus.tx_en;
            default: bus.tx_en = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check_eq("rst_data_ready", bus.data_ready, 0);
         check_eq("rst_in_ready", bus.in_ready, 0);
         exp_q.delete();
         byte_idx = 0; model_sent = 0; err_seen = 0; illegal_pushed = 0;
         halt_cyc = NEVER; last_end_cyc = -1;
         gap_pend = 0; err_prev = 0; prev_valid = 0;
      end else begin
         if (gap_pend) begin
            check_eq("gap_after_instr", bus.data_ready, 0);
            gap_pend = 0;
         end
         check_eq("halted", halted, (cyc >= halt_cyc) ? 1 : 0);
         if (cyc >= halt_cyc) check_eq("in_ready_halted", bus.in_ready, 0);
         if (bus.data_ready) begin
            strobe_cyc.push_back(cyc);
            check_eq("strobe_after_halt", (halt_cyc != NEVER) ? 1 : 0, 0);
            check_eq("strobe_pending", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
               check_eq("strobe_legal_head", legal(exp_q[0].instr), 1);
               if (legal(exp_q[0].instr)) begin
                  if (byte_idx == 0 && last_end_cyc >= 0)
                     check_eq("issue_spacing", (cyc - last_end_cyc >= GAP + 3) ? 1 : 0, 1);
                  check_eq($sformatf("byte%0d", byte_idx), bus.serial_out, exp_byte(exp_q[0], byte_idx));
                  byte_idx++;
                  if (byte_idx == nbytes(exp_q[0].instr)) begin
                     if (exp_q[0].instr[2:0] == 3'd5) halt_cyc = cyc + 1 + GAP;
                     void'(exp_q.pop_front());
                     byte_idx = 0;
                     model_sent++;
                     gap_pend = 1;
                     last_end_cyc = cyc;
                  end
               end
            end
         end else if (prev_valid) begin
            check_eq("serial_hold", bus.serial_out, prev_serial);
         end
         if (err) begin
            err_seen++;
            check_eq("err_width", err_prev, 0);
            check_eq("err_head_illegal", (exp_q.size() != 0 && !legal(exp_q[0].instr)) ? 1 : 0, 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         err_prev = err;
         if (bus.in_valid && bus.in_ready) begin
            item_t it;
            it.instr = bus.in_instr;
            it.imm   = bus.in_imm;
            exp_q.push_back(it);
            push_cyc.push_back(cyc);
            if (!legal(it.instr)) illegal_pushed++;
         end
         if (bus.in_valid && !bus.in_ready) stall_seen = 1;
         prev_serial = bus.serial_out;
         prev_valid  = 1;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      strobe_cyc.delete();
      push_cyc.delete();
      stall_seen = 0;
   endtask

   task automatic push(input logic [15:0] instr, input logic [15:0] imm);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_imm   = imm;
      for (int c = 0; c < 2000 && !ok; c++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1;
      end
      if (ok) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_eq("push_accepted", ok, 1);
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int c = 0; c < 5000 && !ok; c++) begin
         @(negedge clk);
         if (halted || (exp_q.size() == 0 && !busy && !gap_pend)) ok = 1;
      end
      check_eq("drain_done", ok, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      int          n_strobes;
      bus.in_valid = 1'b0;
      bus.in_instr = 16'h0000;
      bus.in_imm   = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_halted", halted, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_err", err, 0);
      check_eq("reset_sent_count", sent_count, 0);
      check_eq("reset_serial_out", bus.serial_out, 0);
      check_eq("reset_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // R_TYPE with tx_en held high: two consecutive bytes at minimum latency.
      tx_mode = 0;
      push(16'hA5C0, 16'h1111);
      wait_drain();
      check_eq("r_strobes", strobe_cyc.size(), 2);
      if (strobe_cyc.size() == 2 && push_cyc.size() == 1) begin
         check_eq("r_consecutive", strobe_cyc[1] - strobe_cyc[0], 1);
         check_eq("r_latency", strobe_cyc[0] - push_cyc[0], 3);
      end
      check_eq("r_sent_count", sent_count, 1);

      // I_TYPE with toggling tx_en: exactly four strobes.
      do_reset();
      tx_mode = 2;
      push(16'h1239, 16'hBEEF);
      wait_drain();
      check_eq("i_strobes", strobe_cyc.size(), 4);
      check_eq("i_sent_count", sent_count, 1);

      // Back-to-back pushes overrun DEPTH=2 and must stall.
      do_reset();
      tx_mode = 0;
      push(16'h1110, 16'h0);
      push(16'h2222, 16'h0);
      push(16'h3333, 16'h0);
      push(16'h4448, 16'h0);
      wait_drain();
      check_eq("b2b_stall_seen", stall_seen, 1);
      check_eq("b2b_strobes", strobe_cyc.size(), 8);
      check_eq("b2b_sent_count", sent_count, 4);

      // Illegal opcode dropped with a single err pulse.
      do_reset();
      push(16'hFFFF, 16'h1234);
      push(16'h5678, 16'h0);
      wait_drain();
      check_eq("ill_err_count", err_seen, 1);
      check_eq("ill_strobes", strobe_cyc.size(), 2);
      check_eq("ill_sent_count", sent_count, 1);

      // SYS_END halts; the queued R_TYPE is never sent.
      do_reset();
      push(16'h00F5, 16'h0);
      push(16'h7770, 16'h0);
      wait_drain();
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("sys_halted", halted, 1);
      check_eq("sys_in_ready", bus.in_ready, 0);
      check_eq("sys_strobes", strobe_cyc.size(), 2);
      check_eq("sys_sent_count", sent_count, 1);
      do_reset();
      @(negedge clk);
      check_eq("sys_rst_halted", halted, 0);
      check_eq("sys_rst_in_ready", bus.in_ready, 1);
      check_eq("sys_rst_busy", busy, 0);
      @(posedge clk);
      #1;

      // Reset in B2 of an M_TYPE aborts it.
      do_reset();
      push(16'hABC4, 16'h7788);
      begin
         bit seen2 = 0;
         for (int c = 0; c < 100 && !seen2; c++) begin
            @(negedge clk);
            if (strobe_cyc.size() >= 2) seen2 = 1;
         end
         check_eq("m_two_bytes", seen2, 1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_strobes = strobe_cyc.size();
      @(negedge clk);
      check_eq("abort_data_ready", bus.data_ready, 0);
      check_eq("abort_serial_out", bus.serial_out, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_sent_count", sent_count, 0);
      repeat (10) @(negedge clk);
      check_eq("abort_no_strobes", strobe_cyc.size(), n_strobes);
      @(posedge clk);
      #1;

      // Randomized mix of legal and illegal instructions with random tx_en.
      do_reset();
      tx_mode = 1;
      for (int i = 0; i < 80; i++) begin
         r = $urandom;
         if (r[2:0] == 3'd5) r[2:0] = 3'd2;
         push(r[15:0], 16'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_drain();
      check_eq("rand_sent_count", sent_count, model_sent);
      check_eq("rand_err_count", err_seen, illegal_pushed);
      check_eq("rand_queue_empty", exp_q.size(), 0);
      check_eq("rand_halted", halted, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_byte_serializer.md
Name: instr_byte_serializer

Overview:
Transmit side of the CPU's 8-bit instruction byte link. Accepts whole instructions (16-bit instruction word plus 16-bit immediate) over a valid/ready handshake and buffers them in a small FIFO. Emits each instruction as 2 bytes (R/B/J/SYS_END) or 4 bytes (I/M) on serial_out, with a one-cycle data_ready strobe per byte. Sits on the memory/host side and drives the CPU's instruction shift-register inputs directly.

Parameters:
DEPTH, 2, input FIFO entries; power of two, minimum 2
GAP_CYCLES, 1, idle cycles forced after the last byte of every instruction; minimum 1

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream offers an instruction
in_ready  output  1  FIFO not full and not halted
in_instr  input  16  instruction word; opcode in bits [2:0]
in_imm  input  16  immediate; ignored for 2-byte opcodes
tx_en  input  1  receiver may take a byte this cycle
serial_out  output  8  current byte
data_ready  output  1  one-cycle strobe: serial_out valid this cycle
busy  output  1  FSM not in IDLE or HALTED, or FIFO non-empty
halted  output  1  SYS_END fully sent; sticky until rst
err  output  1  one-cycle pulse: illegal opcode dropped
sent_count  output  16  completed instructions, wraps at 16'hFFFF -> 0

Behaviour:
- Reset, synchronous and active-high: FIFO emptied; FSM to IDLE; serial_out=0, data_ready=0, busy=0, halted=0, err=0, sent_count=0. in_ready=0 while rst is high. A rst mid-instruction aborts it and no further bytes are emitted.
- Push: occurs when in_valid & in_ready. in_ready = !full & !halted. There is no bypass: a full FIFO rejects input even when a pop happens in the same cycle.
- Byte order: little-endian, matching the receiver. Order is instr[7:0], instr[15:8], then for I/M imm[7:0], imm[15:8].
- FSM states: IDLE, LOAD, B0, B1, B2, B3, GAP, HALTED.
  - IDLE: if FIFO is non-empty, pop the head into the holding register and go to LOAD.
  - LOAD: decode opcode_t from holding[2:0].
    - Illegal opcode: err=1 for this cycle, no bytes sent, go to IDLE.
    - Any legal opcode: go to B0.
  - Bn: serial_out is driven with byte n and data_ready = tx_en. Advance only on cycles where tx_en=1; hold the state otherwise.
  - B1 exit: if R/B/J/SYS_END, the instruction is complete; otherwise go to B2.
  - B3 exit: the instruction is complete.
  - On completion: sent_count++ and go to GAP.
  - GAP: counts GAP_CYCLES cycles with data_ready=0. Then:
    - if the completed instruction was SYS_END, go to HALTED;
    - otherwise go to IDLE.
  - HALTED: halted=1, no pops; only rst exits.
- The GAP is mandatory. The receiver clears its byte count one cycle after the last byte, and a back-to-back byte would be miscounted.
- serial_out holds its last byte value while data_ready=0; it is not zeroed.
- Minimum issue cost with tx_en held at 1:
  - 2-byte instruction: 1 (IDLE) + 1 (LOAD) + 2 + GAP_CYCLES cycles.
  - 4-byte instruction: same, with 4 byte cycles instead of 2.
- Throughput is limited by the FSM, not by DEPTH.
- in_imm is stored for every entry. The imm bytes of 2-byte opcodes are never emitted.

Decomposition:
- Shared package (existing): opcode_t enum with R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE, SYS_END. Add to it:
  - function is_long_op (I/M → 1);
  - function is_legal_op;
  - localparam INSTR_W = 16.
- Local enum for the FSM states.
- One sub-module: instr_fifo, a synchronous DEPTH x 32 FIFO with full/empty flags and a pointer wrap bit.

Test Plan:
- One R_TYPE push, instr=16'hA5C0 with opcode field set to R_TYPE, tx_en=1 → bytes 8'hC0 then 8'hA5 on consecutive cycles; then ≥1 cycle with data_ready=0; sent_count=1.
- One I_TYPE push, instr=16'h1238|I_TYPE, imm=16'hBEEF, tx_en toggling 1,0,1,0 → exactly 4 strobes: 8'h38|I_TYPE, 8'h12, 8'hEF, 8'hBE; serial_out holds its value during tx_en=0 cycles.
- Push 3 instructions back-to-back with tx_en=1 and DEPTH=2 → 3rd push stalls (in_ready=0) until the 1st is popped; all bytes arrive in order; GAP separates every instruction.
- Illegal opcode push, then R_TYPE → err pulses exactly 1 cycle, zero strobes for the illegal entry, R_TYPE bytes follow; sent_count=1.
- SYS_END push followed by an R_TYPE push → 2 SYS_END bytes, then halted=1 and in_ready=0; the R_TYPE is never sent; rst clears halted and in_ready returns to 1.
- Assert rst in B2 of an M_TYPE → no strobes after rst; outputs return to reset values next cycle; FIFO is empty (busy=0).
